crypto1_keystream: RTL and testbench



---
 rtl/crypto1_pkg.sv | 16 +
 rtl/crypto1_filter.sv | 22 ++
 rtl/crypto1_keystream.sv | 102 ++++++++++
 tb/tb_crypto1_keystream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/crypto1_pkg.sv
// Shared Crypto-1 constants: filter lookup tables, LFSR feedback taps and FSM state type.
package crypto1_pkg;

  localparam logic [15:0] FA_LUT = 16'h9E98;
  localparam logic [15:0] FB_LUT = 16'hB48E;
  localparam logic [31:0] FC_LUT = 32'hEC57E80A;

  // Taps 0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43
  localparam logic [47:0] LFSR_TAPS = 48'h0E88_2B0A_D621;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } fsm_e;

endpackage

// File: rtl/crypto1_filter.sv
// Combinational Crypto-1 nonlinear filter: 48-bit LFSR state to one keystream bit.
module crypto1_filter
  import crypto1_pkg::*;
(
  input  logic [47:0] state_i,
  output logic        bit_o
);

  logic [3:0] n0, n1, n2, n3, n4;
  logic [4:0] fc_idx;

  // Odd-indexed bits only; the first-listed bit of each nibble is its MSB
  assign n0 = {state_i[15], state_i[13], state_i[11], state_i[9]};
  assign n1 = {state_i[23], state_i[21], state_i[19], state_i[17]};
  assign n2 = {state_i[31], state_i[29], state_i[27], state_i[25]};
  assign n3 = {state_i[39], state_i[37], state_i[35], state_i[33]};
  assign n4 = {state_i[47], state_i[45], state_i[43], state_i[41]};

  assign fc_idx = {FB_LUT[n4], FA_LUT[n3], FB_LUT[n2], FB_LUT[n1], FA_LUT[n0]};
  assign bit_o  = FC_LUT[fc_idx];

endmodule

// File: rtl/crypto1_keystream.sv
// Forward Crypto-1 keystream generator with valid/ready output stream.
// Optional nonce feed-in ports FEED_BIT/FEED_ENC are enabled by CRYPTO1_FEEDIN_EN.
module crypto1_keystream
  import crypto1_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [47:0]      STATE_IN,
  input  logic [CNT_W-1:0] COUNT,
  output logic             KS_BIT,
  output logic             KS_VALID,
  input  logic             KS_READY,
  output logic             BUSY,
  output logic             DONE,
`ifdef CRYPTO1_FEEDIN_EN
  input  logic             FEED_BIT,
  input  logic             FEED_ENC,
`endif
  output logic [47:0]      STATE_OUT
);

  fsm_e             fsm_q;
  logic [47:0]      state_q;
  logic [47:0]      shift_d;
  logic [CNT_W-1:0] ctr_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             ks_bit;
  logic             fb;
  logic             fb_in;

  crypto1_filter u_filter (
    .state_i (state_q),
    .bit_o   (ks_bit)
  );

  assign fb = ^(state_q & LFSR_TAPS);

`ifdef CRYPTO1_FEEDIN_EN
  assign fb_in = fb ^ FEED_BIT ^ (FEED_ENC & ks_bit);
`else
  assign fb_in = fb;
`endif

  assign shift_d = {fb_in, state_q[47:1]};

  // LOAD has priority over a same-cycle handshake: the offered bit is dropped
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      ctr_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (LOAD) begin
        state_q <= STATE_IN;
        ctr_q   <= COUNT;
        if (COUNT != '0) begin
          fsm_q   <= StRun;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
        end else begin
          fsm_q   <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end else begin
        unique case (fsm_q)
          StIdle: ;
          StRun: begin
            if (KS_READY) begin
              state_q <= shift_d;
              ctr_q   <= ctr_q - CNT_W'(1);
              if (ctr_q == CNT_W'(1)) begin
                fsm_q   <= StIdle;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: fsm_q <= StIdle;
        endcase
      end
    end
  end

  assign KS_BIT    = ks_bit;
  assign KS_VALID  = valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign STATE_OUT = state_q;

endmodule

// File: tb/tb_crypto1_keystream.sv
// Self-checking bench for crypto1_keystream: table vectors, corner sequences, random runs.
module tb_crypto1_keystream;

`ifdef CRYPTO1_FEEDIN_EN
  localparam bit FeedOn = 1'b1;
`else
  localparam bit FeedOn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        LOAD = 1'b0;
  logic [47:0] STATE_IN = '0;
  logic [15:0] COUNT = '0;
  logic        KS_BIT;
  logic        KS_VALID;
  logic        KS_READY = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic        FEED_BIT = 1'b0;
  logic        FEED_ENC = 1'b0;
  logic [47:0] STATE_OUT;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  crypto1_keystream #(.CNT_W(16)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .LOAD      (LOAD),
    .STATE_IN  (STATE_IN),
    .COUNT     (COUNT),
    .KS_BIT    (KS_BIT),
    .KS_VALID  (KS_VALID),
    .KS_READY  (KS_READY),
    .BUSY      (BUSY),
    .DONE      (DONE),
`ifdef CRYPTO1_FEEDIN_EN
    .FEED_BIT  (FEED_BIT),
    .FEED_ENC  (FEED_ENC),
`endif
    .STATE_OUT (STATE_OUT)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: filter built from nibble lookups, feedback from the tap list
  function automatic logic model_filter(input logic [47:0] s);
    logic [15:0] fa_tab = 16'h9E98;
    logic [15:0] fb_tab = 16'hB48E;
    logic [31:0] fc_tab = 32'hEC57E80A;
    int base [5] = '{9, 17, 25, 33, 41};
    int idx = 0;
    for (int k = 0; k < 5; k++) begin
      int x;
      int b;
      x = 8 * int'(s[base[k] + 6]) + 4 * int'(s[base[k] + 4]) + 2 * int'(s[base[k] + 2])
          + int'(s[base[k]]);
      b = (k == 0 || k == 3) ? int'(fa_tab[x]) : int'(fb_tab[x]);
      idx += b << k;
    end
    return fc_tab[idx];
  endfunction

  function automatic logic [47:0] model_step(input logic [47:0] s, input logic fbit,
                                             input logic fenc);
    int taps [18] = '{0, 5, 9, 10, 12, 14, 15, 17, 19, 24, 25, 27, 29, 35, 39, 41, 42, 43};
    logic f = 1'b0;
    for (int k = 0; k < 18; k++) f ^= s[taps[k]];
    f = f ^ fbit ^ (fenc & model_filter(s));
    return {f, s[47:1]};
  endfunction

  function automatic logic [47:0] model_run(input logic [47:0] s, input int cnt);
    logic [47:0] r = s;
    for (int k = 0; k < cnt; k++) r = model_step(r, 1'b0, 1'b0);
    return r;
  endfunction

  task automatic load(input logic [47:0] st, input int cnt);
    @(negedge CLK);
    KS_READY = 1'b0;
    LOAD     = 1'b1;
    STATE_IN = st;
    COUNT    = 16'(cnt);
    @(negedge CLK);
    LOAD = 1'b0;
  endtask

  // Called at the negedge after LOAD; consumes the whole run and checks every cycle
  task automatic drain(input logic [47:0] st, input int cnt, input int rmode, input bit feed,
                       input string name, output logic first, output logic [47:0] fin);
    logic [47:0] ms = st;
    logic [6:0]  pat = 7'b1011001;
    int          got = 0;
    int          cyc = 0;
    logic        eb, r, fbit, fenc;
    first = 1'b0;
    if (cnt == 0) begin
      chk({name, " c0 done"}, 48'(DONE), 48'd1);
      chk({name, " c0 valid"}, 48'(KS_VALID), 48'd0);
      chk({name, " c0 state"}, STATE_OUT, st);
    end else begin
      while (got < cnt && cyc < 8 * cnt + 16) begin
        eb = model_filter(ms);
        chk({name, " valid"}, 48'(KS_VALID), 48'd1);
        chk({name, " busy"}, 48'(BUSY), 48'd1);
        chk({name, " early done"}, 48'(DONE), 48'd0);
        chk({name, " bit"}, 48'(KS_BIT), 48'(eb));
        chk({name, " state"}, STATE_OUT, ms);
        case (rmode)
          0:       r = 1'b1;
          1:       r = pat[cyc % 7];
          default: r = 1'($urandom_range(0, 1));
        endcase
        fbit = (feed && FeedOn) ? 1'($urandom_range(0, 1)) : 1'b0;
        fenc = (feed && FeedOn) ? 1'($urandom_range(0, 1)) : 1'b0;
        KS_READY = r;
        FEED_BIT = fbit;
        FEED_ENC = fenc;
        if (r) begin
          if (got == 0) first = eb;
          ms = model_step(ms, fbit, fenc);
          got++;
        end
        cyc++;
        @(negedge CLK);
      end
      KS_READY = 1'b0;
      FEED_BIT = 1'b0;
      FEED_ENC = 1'b0;
      chk({name, " handshakes"}, 48'(got), 48'(cnt));
      chk({name, " done"}, 48'(DONE), 48'd1);
      chk({name, " end valid"}, 48'(KS_VALID), 48'd0);
      chk({name, " end busy"}, 48'(BUSY), 48'd0);
      chk({name, " end state"}, STATE_OUT, ms);
    end
    fin = STATE_OUT;
    @(negedge CLK);
    chk({name, " done low"}, 48'(DONE), 48'd0);
  endtask

  typedef struct {
    logic [47:0] st;
    int          cnt;
    int          rmode;
    logic [47:0] exp_fin;
    logic        exp_first;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    logic        first;
    logic [47:0] fin, a, b, ms;

    vecs[0] = '{48'h0, 8, 0, 48'h0, 1'b0};
    vecs[1] = '{48'hFFFF_FFFF_FFFF, 1, 0, 48'h7FFF_FFFF_FFFF, 1'b1};
    vecs[2] = '{48'h1234_5678_9ABC, 4, 1, model_run(48'h1234_5678_9ABC, 4),
                model_filter(48'h1234_5678_9ABC)};
    vecs[3] = '{48'hA5A5_5A5A_C3C3, 0, 0, 48'hA5A5_5A5A_C3C3, 1'b0};
    vecs[4] = '{48'hDEAD_BEEF_0123, 20, 2, model_run(48'hDEAD_BEEF_0123, 20),
                model_filter(48'hDEAD_BEEF_0123)};

    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk("reset valid", 48'(KS_VALID), 48'd0);
    chk("reset busy", 48'(BUSY), 48'd0);
    chk("reset done", 48'(DONE), 48'd0);
    chk("reset state", STATE_OUT, 48'h0);

    for (int i = 0; i < 5; i++) begin
      load(vecs[i].st, vecs[i].cnt);
      drain(vecs[i].st, vecs[i].cnt, vecs[i].rmode, 1'b0, $sformatf("vec%0d", i), first, fin);
      chk($sformatf("vec%0d final", i), fin, vecs[i].exp_fin);
      if (vecs[i].cnt != 0) chk($sformatf("vec%0d first", i), 48'(first), 48'(vecs[i].exp_first));
    end

    // Abort: reload mid-run, expect restart from new state without DONE
    a  = 48'h0F1E_2D3C_4B5A;
    b  = 48'h7766_5544_3322;
    ms = a;
    load(a, 10);
    for (int k = 0; k < 3; k++) begin
      chk("abort pre bit", 48'(KS_BIT), 48'(model_filter(ms)));
      KS_READY = 1'b1;
      ms = model_step(ms, 1'b0, 1'b0);
      @(negedge CLK);
    end
    chk("abort pre state", STATE_OUT, ms);
    KS_READY = 1'b0;
    LOAD     = 1'b1;
    STATE_IN = b;
    COUNT    = 16'd5;
    @(negedge CLK);
    LOAD = 1'b0;
    chk("abort no done", 48'(DONE), 48'd0);
    drain(b, 5, 0, 1'b0, "abort", first, fin);
    chk("abort final", fin, model_run(b, 5));

    // Reset mid-run
    load(a, 10);
    KS_READY = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET    = 1'b0;
    KS_READY = 1'b0;
    chk("rst valid", 48'(KS_VALID), 48'd0);
    chk("rst busy", 48'(BUSY), 48'd0);
    chk("rst done", 48'(DONE), 48'd0);
    chk("rst state", STATE_OUT, 48'h0);
    @(negedge CLK);
    chk("rst stays idle", 48'(KS_VALID), 48'd0);

    // Random states, full-rate, with feed-in when enabled
    for (int i = 0; i < 1000; i++) begin
      a = {16'($urandom), $urandom};
      load(a, 64);
      drain(a, 64, 0, 1'b1, "rand", first, fin);
    end
    for (int i = 0; i < 5; i++) begin
      a = {16'($urandom), $urandom};
      load(a, 64);
      drain(a, 64, 2, 1'b1, "randbp", first, fin);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
